// File: rtl/serial_subtractor_ctrl_pkg.sv
// serial_subtractor_ctrl_pkg: shared state encoding for the bit-serial subtractor
package serial_subtractor_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_ctrl_full_subtractor.sv
// full_subtractor: combinational one-bit x - y - z cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic diff,
  output logic borrow
);
  assign diff   = x ^ y ^ z;
  assign borrow = (~x & y) | (~(x ^ y) & z);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: a - b - bin computed LSB first, one bit per clock, through one cell
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb, r_sd, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br, r_a_msb, r_b_msb, r_done, r_borrow, r_ovf;
  logic             w_d, w_b;
  full_subtractor u_cell (
    .x(r_sa[0]),
    .y(r_sb[0]),
    .z(r_br),
    .diff(w_d),
    .borrow(w_b)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sd     <= '0;
      r_br     <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          r_sa    <= a;
          r_sb    <= b;
          r_br    <= bin;
          r_cnt   <= '0;
          r_a_msb <= a[WIDTH-1];
          r_b_msb <= b[WIDTH-1];
        end
        RUN: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_sd    <= {w_d, r_sd[WIDTH-1:1]};
          r_br    <= w_b;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == CW'(WIDTH - 1)) ? DONE : RUN;
        end
        DONE: begin
          r_done   <= 1'b1;
          r_diff   <= r_sd;
          r_borrow <= r_br;
          r_ovf    <= (r_a_msb ^ r_b_msb) & (r_sd[WIDTH-1] ^ r_a_msb);
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;
endmodule
